// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared definitions for the data memory responder: FSM state encoding,
//   request opcode encoding, the default access latency and the width of the
//   latency down-counter.
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  // Down-counter width; wide enough for any latency in 1..15.
  localparam int DM_CNT_W = 4;

  // Default number of ACCESS cycles per request.
  localparam int DM_LATENCY_DEFAULT = 5;

  typedef enum logic [1:0] {
    DM_IDLE   = 2'd0,
    DM_ACCESS = 2'd1,
    DM_DONE   = 2'd2
  } dm_state_e;

  typedef enum logic {
    DM_OP_RD = 1'b0,
    DM_OP_WR = 1'b1
  } dm_op_e;

endpackage : data_mem_responder_pkg

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//   CPU <-> data memory load/store bus.
//   READ_MEM / WRITE_MEM : request strobes, held by the CPU until BUSY drops
//   MEM_ADRESS           : byte address of the access
//   WRITE_DATA           : store data
//   MEM_OUT              : registered read data
//   BUSY                 : stall request back to the CPU
//   PROTO_ERR            : sticky "read and write requested together" flag
//   Modports: master = CPU side, slave = memory side.
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              READ_MEM;
  logic              WRITE_MEM;
  logic [ADDR_W-1:0] MEM_ADRESS;
  logic [DATA_W-1:0] WRITE_DATA;
  logic [DATA_W-1:0] MEM_OUT;
  logic              BUSY;
  logic              PROTO_ERR;

  modport master (
    output READ_MEM,
    output WRITE_MEM,
    output MEM_ADRESS,
    output WRITE_DATA,
    input  MEM_OUT,
    input  BUSY,
    input  PROTO_ERR
  );

  modport slave (
    input  READ_MEM,
    input  WRITE_MEM,
    input  MEM_ADRESS,
    input  WRITE_DATA,
    output MEM_OUT,
    output BUSY,
    output PROTO_ERR
  );

endinterface : data_mem_responder_if

// File: rtl/data_mem_responder_access_timer.sv
// -----------------------------------------------------------------------------
// data_mem_responder_access_timer
//   Loadable down-counter that times the slow-memory access window.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (count cleared to 0)
//   load     : load load_val into the counter (has priority over en)
//   load_val : value to load
//   en       : decrement by one; the counter saturates at zero
//   zero     : counter currently equals zero
// -----------------------------------------------------------------------------
module data_mem_responder_access_timer
  import data_mem_responder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [DM_CNT_W-1:0] load_val,
  input  logic                en,
  output logic                zero
);

  logic [DM_CNT_W-1:0] count_q;
  logic [DM_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule : data_mem_responder_access_timer

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Byte-addressed data memory serving CPU loads/stores with a fixed access
//   latency. A request accepted in IDLE spends LATENCY cycles in ACCESS, the
//   array is read or written on the last ACCESS edge, then one DONE cycle with
//   BUSY low lets the CPU commit before the FSM returns to IDLE.
//   CLK   : clock, all state changes on posedge
//   RESET : asynchronous active-low reset; clears FSM, outputs and every byte
//   bus   : slave side of the load/store bus (see data_mem_responder_if)
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = DM_LATENCY_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  data_mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DM_CNT_W-1:0] LOAD_VAL = DM_CNT_W'(LATENCY - 1);

  dm_state_e         state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] data_q,      data_d;
  dm_op_e            op_q,        op_d;
  logic [DATA_W-1:0] mem_out_q,   mem_out_d;
  logic              proto_err_q, proto_err_d;

  // Storage is flop-based: reset must clear every byte asynchronously.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic mem_we;
  logic tmr_load;
  logic tmr_en;
  logic tmr_zero;
  logic req;

  assign req = bus.READ_MEM || bus.WRITE_MEM;

  data_mem_responder_access_timer u_timer (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    op_d        = op_q;
    mem_out_d   = mem_out_q;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      DM_IDLE: begin
        if (req) begin
          addr_d   = bus.MEM_ADRESS;
          data_d   = bus.WRITE_DATA;
          // A simultaneous read+write is served as a read; the write is dropped.
          op_d     = bus.READ_MEM ? DM_OP_RD : DM_OP_WR;
          if (bus.READ_MEM && bus.WRITE_MEM) begin
            proto_err_d = 1'b1;
          end
          tmr_load = 1'b1;
          state_d  = DM_ACCESS;
        end
      end

      DM_ACCESS: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          if (op_q == DM_OP_RD) begin
            mem_out_d = mem_q[addr_q];
          end else begin
            mem_we = 1'b1;
          end
          state_d = DM_DONE;
        end
      end

      // Requests are deliberately ignored here so a request still held by the
      // CPU through its commit cycle is not accepted a second time.
      DM_DONE: begin
        state_d = DM_IDLE;
      end

      default: begin
        state_d = DM_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= DM_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      op_q        <= DM_OP_RD;
      mem_out_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      op_q        <= op_d;
      mem_out_q   <= mem_out_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= data_q;
    end
  end

  // The stall is raised in the same cycle a request appears in IDLE. It is
  // gated by RESET so it falls immediately when reset is asserted, even if the
  // CPU is still holding a request line high.
  assign bus.BUSY = RESET &&
                    (((state_q == DM_IDLE) && req) || (state_q == DM_ACCESS));

  assign bus.MEM_OUT   = mem_out_q;
  assign bus.PROTO_ERR = proto_err_q;

endmodule : data_mem_responder
